jt12_eg_adsr: RTL



---
 rtl/jt12_eg_adsr_if.sv | 26 ++
 rtl/jt12_eg_adsr.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/jt12_eg_adsr_if.sv
// Slot-parameter inputs and processed-slot envelope outputs of the ADSR engine.
// The bench drives through master; the engine attaches as slave.
interface jt12_eg_adsr_if;
  logic       keyon;
  logic [4:0] ar;
  logic [4:0] d1r;
  logic [4:0] d2r;
  logic [3:0] rr;
  logic [3:0] sl;
  logic [4:0] keycode;
  logic [1:0] ks;
  logic [4:0] slot;
  logic [9:0] eg_pure_out;
  logic [1:0] eg_state;
  logic       eg_tick;

  modport master (
    output keyon, ar, d1r, d2r, rr, sl, keycode, ks,
    input  slot, eg_pure_out, eg_state, eg_tick
  );

  modport slave (
    input  keyon, ar, d1r, d2r, rr, sl, keycode, ks,
    output slot, eg_pure_out, eg_state, eg_tick
  );
endinterface

// File: rtl/jt12_eg_adsr.sv
// Time-multiplexed ADSR envelope engine: one slot per clk_en, per-slot attenuation,
// state and key history held in flop arrays indexed by the slot counter.
module jt12_eg_adsr #(
  parameter int NSLOTS = 24,
  parameter int CNTW   = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clk_en,
  jt12_eg_adsr_if.slave  eg
);

  typedef enum logic [1:0] {
    ST_ATTACK  = 2'd0,
    ST_DECAY   = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_RELEASE = 2'd3
  } eg_state_e;

  logic [4:0]      slot_q, slot_d;
  logic [1:0]      div3_q, div3_d;
  logic [CNTW-1:0] eg_cnt_q, eg_cnt_d;
  logic            eg_tick_q, eg_tick_d;
  logic [9:0]      eg_pure_out_q, eg_pure_out_d;
  eg_state_e       eg_state_q, eg_state_d;

  logic [9:0]        att_q [NSLOTS];
  eg_state_e         st_q  [NSLOTS];
  logic [NSLOTS-1:0] kon_prev_q;

  logic [9:0]  att_cur, att_d, slv;
  eg_state_e   st_cur, st_d;
  logic        kon_cur, kon_prev_d, rise, fall;
  logic [4:0]  base_r, inc;
  logic [5:0]  rate, ar_rate;
  logic [13:0] prod;
  logic [10:0] dec, sum;

  function automatic logic [5:0] eff_rate(input logic [4:0] r, input logic [4:0] kc,
                                          input logic [1:0] ksv);
    logic [6:0] total;
    total = {1'b0, r, 1'b0} + 7'(kc >> (2'd3 - ksv));
    if (r == 5'd0)          return 6'd0;
    else if (total > 7'd63) return 6'd63;
    else                    return total[5:0];
  endfunction

  function automatic logic [4:0] step_inc(input logic [5:0] rt, input logic [CNTW-1:0] cnt);
    logic [7:0]      pat;
    logic [3:0]      shift;
    logic [CNTW-1:0] mask;
    logic [2:0]      idx;
    case (rt[1:0])
      2'd0:    pat = 8'b1010_1010;
      2'd1:    pat = 8'b1011_1010;
      2'd2:    pat = 8'b1110_1110;
      default: pat = 8'b1111_1110;
    endcase
    shift = 4'd11 - rt[5:2];
    mask  = (CNTW'(1) << shift) - CNTW'(1);
    idx   = 3'(cnt >> shift);
    if (rt < 6'd4)       return 5'd0;
    else if (rt < 6'd48) return ((cnt & mask) == '0) ? {4'd0, pat[idx]} : 5'd0;
    else if (rt < 6'd62) return (5'd1 + {4'd0, pat[cnt[2:0]]}) << (rt[5:2] - 4'd12);
    else                 return 5'd8;
  endfunction

  assign att_cur    = att_q[slot_q];
  assign st_cur     = st_q[slot_q];
  assign kon_cur    = kon_prev_q[slot_q];
  assign kon_prev_d = eg.keyon;
  assign rise       = eg.keyon & ~kon_cur;
  assign fall       = ~eg.keyon & kon_cur;
  assign slv        = (eg.sl == 4'd15) ? 10'h3E0 : {eg.sl, 5'b0};

  // Slot sequencing and the global envelope clock.
  always_comb begin
    slot_d    = slot_q + 5'd1;
    div3_d    = div3_q;
    eg_cnt_d  = eg_cnt_q;
    eg_tick_d = eg_tick_q;
    if (slot_q == 5'(NSLOTS - 1)) begin
      slot_d    = 5'd0;
      eg_tick_d = (div3_q == 2'd2);
      if (div3_q == 2'd2) begin
        div3_d   = 2'd0;
        eg_cnt_d = eg_cnt_q + CNTW'(1);
      end else begin
        div3_d = div3_q + 2'd1;
      end
    end
  end

  // Envelope next-state for the slot currently on the slot output.
  always_comb begin
    case (st_cur)
      ST_ATTACK:  base_r = eg.ar;
      ST_DECAY:   base_r = eg.d1r;
      ST_SUSTAIN: base_r = eg.d2r;
      default:    base_r = {eg.rr, 1'b1};
    endcase
    rate    = eff_rate(base_r, eg.keycode, eg.ks);
    ar_rate = eff_rate(eg.ar, eg.keycode, eg.ks);
    inc     = eg_tick_q ? step_inc(rate, eg_cnt_q) : 5'd0;
    prod    = 14'(att_cur) * 14'(inc);
    dec     = 11'(prod >> 4) + 11'd1;
    sum     = {1'b0, att_cur} + 11'(inc);
    att_d   = att_cur;
    st_d    = st_cur;

    if (rise) begin
      st_d = ST_ATTACK;
      if (ar_rate >= 6'd62) att_d = 10'd0;
    end else if (fall) begin
      st_d = ST_RELEASE;
    end else if (eg_tick_q) begin
      if (st_cur == ST_ATTACK) begin
        if (inc != 5'd0 && att_cur != 10'd0)
          att_d = (dec >= {1'b0, att_cur}) ? 10'd0 : att_cur - 10'(dec);
        if (att_d == 10'd0) st_d = ST_DECAY;
      end else begin
        att_d = (sum > 11'h3FF) ? 10'h3FF : sum[9:0];
        if (st_cur == ST_DECAY && att_d >= slv) st_d = ST_SUSTAIN;
      end
    end

    eg_pure_out_d = att_d;
    eg_state_d    = st_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q        <= 5'd0;
      div3_q        <= 2'd0;
      eg_cnt_q      <= '0;
      eg_tick_q     <= 1'b0;
      eg_pure_out_q <= 10'h3FF;
      eg_state_q    <= ST_RELEASE;
      kon_prev_q    <= '0;
      // NOTE: slot storage is a flop bank, not a RAM, so one reset cycle clears every slot.
      for (int i = 0; i < NSLOTS; i++) begin
        att_q[i] <= 10'h3FF;
        st_q[i]  <= ST_RELEASE;
      end
    end else if (clk_en) begin
      slot_q             <= slot_d;
      div3_q             <= div3_d;
      eg_cnt_q           <= eg_cnt_d;
      eg_tick_q          <= eg_tick_d;
      eg_pure_out_q      <= eg_pure_out_d;
      eg_state_q         <= eg_state_d;
      att_q[slot_q]      <= att_d;
      st_q[slot_q]       <= st_d;
      kon_prev_q[slot_q] <= kon_prev_d;
    end
  end

  assign eg.slot        = slot_q;
  assign eg.eg_pure_out = eg_pure_out_q;
  assign eg.eg_state    = eg_state_q;
  assign eg.eg_tick     = eg_tick_q;

endmodule
